iir_decim_sink: RTL and testbench

- Receiving end of the SOS cascade's dv/data output stream.
- Pipeline:
  - Decimates the filtered sample stream by a fixed ratio.
  - Requantizes each kept sample from the wide internal Q format to a narrow output word, with round-half-up and saturation.
  - Buffers results in a small FIFO.
  - Presents them on a valid/ready handshake so downstream logic can apply backpressure, which the dv-only filter interface cannot do.

---
 rtl/iir_decim_sink.sv | 131 +++++++++++++
 tb/tb_iir_decim_sink.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_decim_sink.sv
// Decimating sink for the SOS cascade output. It keeps every Ndecim-th sample,
// rounds and saturates it to the output Q format, and buffers it behind a valid/ready port.
module iir_decim_sink #(
  parameter int Ndint  = 3,
  parameter int Ndfrac = 22,
  parameter int Noint  = 1,
  parameter int Nofrac = 15,
  parameter int Ndecim = 4,
  parameter int Depth  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dv_in,
  input  logic signed [Ndint-1:-Ndfrac]  d_in,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic signed [Noint-1:-Nofrac]  m_data,
  output logic [$clog2(Depth):0]         fifo_count,
  output logic                           sat_pulse,
  output logic                           overflow
);

  localparam int Win  = Ndint + Ndfrac;
  localparam int Wr   = Ndint + 1 + Nofrac;
  localparam int Wo   = Noint + Nofrac;
  localparam int Drop = Ndfrac - Nofrac;
  localparam int Cw   = (Ndecim > 1) ? $clog2(Ndecim) : 1;
  localparam int Aw   = $clog2(Depth);

  localparam logic [Win:0]    Half   = {{Win{1'b0}}, 1'b1} << (Drop - 1);
  localparam logic [Wo-1:0]   SatMax = {1'b0, {(Wo-1){1'b1}}};
  localparam logic [Wo-1:0]   SatMin = {1'b1, {(Wo-1){1'b0}}};
  localparam logic [Aw:0]     Full   = (Aw+1)'(Depth);

  if (Noint > Ndint)                     begin : g_bad_noint  $error("Noint must be <= Ndint");    end
  if (Nofrac >= Ndfrac)                  begin : g_bad_nofrac $error("Nofrac must be < Ndfrac");   end
  if (Ndecim < 1)                        begin : g_bad_decim  $error("Ndecim must be >= 1");       end
  if (Depth < 2 || (Depth & (Depth-1)))  begin : g_bad_depth  $error("Depth must be a power of 2 >= 2"); end

  // Decimation phase counter
  logic [Cw-1:0] dec_cnt;
  logic          keep;

  assign keep = dv_in && (dec_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (dv_in) begin
      if (dec_cnt == Cw'(Ndecim - 1)) dec_cnt <= '0;
      else                            dec_cnt <= dec_cnt + Cw'(1);
    end
  end

  // Stage 1: round half-up with one guard integer bit so the carry cannot wrap
  logic [Win:0]  ext;
  logic [Win:0]  rsum;
  logic [Wr-1:0] s1_val;
  logic          s1_v;

  assign ext  = {d_in[Ndint-1], d_in};
  assign rsum = ext + Half;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v   <= 1'b0;
      s1_val <= '0;
    end else begin
      s1_v <= keep;
      if (keep) s1_val <= rsum[Win:Drop];
    end
  end

  // Stage 2: in range when all bits above the output sign agree with it
  logic          in_range;
  logic [Wo-1:0] sat_val;
  logic [Wo-1:0] s2_data;
  logic          s2_v;

  assign in_range = (s1_val[Wr-1:Wo-1] == '0) || (s1_val[Wr-1:Wo-1] == '1);
  assign sat_val  = in_range ? s1_val[Wo-1:0] : (s1_val[Wr-1] ? SatMin : SatMax);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v      <= 1'b0;
      s2_data   <= '0;
      sat_pulse <= 1'b0;
    end else begin
      s2_v      <= s1_v;
      sat_pulse <= s1_v && !in_range;
      if (s1_v) s2_data <= sat_val;
    end
  end

  // Show-ahead FIFO
  logic [Wo-1:0] mem [Depth];
  logic [Aw-1:0] wr_ptr;
  logic [Aw-1:0] rd_ptr;
  logic          full;
  logic          rd;
  logic          wr;

  assign full    = (fifo_count == Full);
  assign m_valid = (fifo_count != '0);
  assign rd      = m_valid && m_ready;
  assign wr      = s2_v && (!full || rd);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + Aw'(1);
      if (rd) rd_ptr <= rd_ptr + Aw'(1);
      case ({wr, rd})
        2'b10:   fifo_count <= fifo_count + (Aw+1)'(1);
        2'b01:   fifo_count <= fifo_count - (Aw+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (s2_v && full && !rd) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_decim_sink.sv
// Scoreboard bench for iir_decim_sink: one instance keeps every sample, a second
// decimates by 4; each has its own expected-word queue and output monitor.
module tb_iir_decim_sink;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               dv1 = 1'b0;
  logic               dv4 = 1'b0;
  logic               m_ready = 1'b0;
  logic signed [24:0] d_in = '0;

  logic        v1, v4, s1, s4, ov1, ov4;
  logic [15:0] d1, d4;
  logic [3:0]  cnt1, cnt4;

  int total = 0;
  int bad = 0;
  int sat_cnt = 0;
  logic [15:0] q1[$];
  logic [15:0] q4[$];

  int          t3_in[4]  = '{64, 63, -64, -65};
  logic [15:0] t3_exp[4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
  int          t2_in[3]  = '{6291456, -12582912, 4194303};
  logic [15:0] t2_exp[3] = '{16'h7FFF, 16'h8000, 16'h7FFF};

  iir_decim_sink #(.Ndecim(1)) dut1 (
    .clk(clk), .reset(rst), .dv_in(dv1), .d_in(d_in),
    .m_valid(v1), .m_ready(m_ready), .m_data(d1),
    .fifo_count(cnt1), .sat_pulse(s1), .overflow(ov1)
  );

  iir_decim_sink #(.Ndecim(4)) dut4 (
    .clk(clk), .reset(rst), .dv_in(dv4), .d_in(d_in),
    .m_valid(v4), .m_ready(m_ready), .m_data(d4),
    .fifo_count(cnt4), .sat_pulse(s4), .overflow(ov4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && v1 && m_ready) begin
      logic [15:0] e;
      if (q1.size() == 0) chk("dut1 unexpected word", 32'(d1), 32'hDEAD_BEEF);
      else begin
        e = q1.pop_front();
        chk("dut1 data", 32'(d1), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && v4 && m_ready) begin
      logic [15:0] e;
      if (q4.size() == 0) chk("dut4 unexpected word", 32'(d4), 32'hDEAD_BEEF);
      else begin
        e = q4.pop_front();
        chk("dut4 data", 32'(d4), 32'(e));
      end
    end
  end

  always @(negedge clk) if (!rst && s1) sat_cnt++;

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int sat_before;

    repeat (2) @(posedge clk);
    #3;
    chk("reset m_valid", 32'(v1), 0);
    chk("reset m_data", 32'(d1), 0);
    chk("reset fifo_count", 32'(cnt1), 0);
    chk("reset sat_pulse", 32'(s1), 0);
    chk("reset overflow", 32'(ov1), 0);
    rst = 1'b0;
    step();

    // 1: 0.5 -> 0x4000, two-cycle latency, one-cycle valid
    m_ready = 1'b1;
    d_in = 25'(2097152);
    dv1 = 1'b1;
    q1.push_back(16'h4000);
    step();
    dv1 = 1'b0;
    chk("t1 valid k", 32'(v1), 0);
    step();
    chk("t1 valid k+1", 32'(v1), 0);
    step();
    chk("t1 valid k+2", 32'(v1), 1);
    chk("t1 data k+2", 32'(d1), 32'h4000);
    step();
    chk("t1 valid k+3", 32'(v1), 0);
    chk("t1 no sat", 32'(sat_cnt), 0);

    // 2: saturation, including the rounding-carry case
    for (int i = 0; i < 3; i++) begin
      d_in = 25'(t2_in[i]);
      dv1 = 1'b1;
      q1.push_back(t2_exp[i]);
      step();
      dv1 = 1'b0;
      chk("t2 sat before", 32'(s1), 0);
      step();
      chk("t2 sat pulse", 32'(s1), 1);
      step();
      chk("t2 sat after", 32'(s1), 0);
      step();
    end
    chk("t2 overflow", 32'(ov1), 0);

    // 3: rounding edges, back to back
    sat_before = sat_cnt;
    for (int i = 0; i < 4; i++) begin
      d_in = 25'(t3_in[i]);
      dv1 = 1'b1;
      q1.push_back(t3_exp[i]);
      step();
    end
    dv1 = 1'b0;
    repeat (6) step();
    chk("t3 no sat", 32'(sat_cnt), 32'(sat_before));
    chk("t3 drained", 32'(q1.size()), 0);

    // 4: decimate by 4 with random gaps
    for (int n = 0; n < 12; n++) begin
      d_in = 25'(n * 128);
      dv4 = 1'b1;
      if (n % 4 == 0) q4.push_back(16'(n));
      step();
      dv4 = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (6) step();
    chk("t4 drained", 32'(q4.size()), 0);

    // 5: fill with no reads, overflow on the 9th, then drain
    m_ready = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      d_in = 25'(n * 128);
      dv1 = 1'b1;
      if (n <= 8) q1.push_back(16'(n));
      step();
    end
    dv1 = 1'b0;
    chk("t5 count full", 32'(cnt1), 8);
    chk("t5 overflow before 9th", 32'(ov1), 0);
    step();
    chk("t5 overflow after 9th", 32'(ov1), 1);
    chk("t5 count held", 32'(cnt1), 8);
    for (int i = 0; i < 3; i++) begin
      chk("t5 stall valid", 32'(v1), 1);
      chk("t5 stall data", 32'(d1), 32'h0001);
      step();
    end
    m_ready = 1'b1;
    guard = 0;
    while (cnt1 != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("t5 final count", 32'(cnt1), 0);
    chk("t5 final valid", 32'(v1), 0);
    chk("t5 queue empty", 32'(q1.size()), 0);

    rst = 1'b1;
    #2;
    chk("reset clears overflow", 32'(ov1), 0);
    chk("reset clears count", 32'(cnt1), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // 6: toggling ready with continuous input, then reset mid-stream
    m_ready = 1'b0;
    d_in = 25'(20 * 128);
    dv4 = 1'b1;
    q4.push_back(16'd20);
    step();
    d_in = 25'(21 * 128);
    step();
    dv4 = 1'b0;
    for (int n = 101; n <= 103; n++) begin
      d_in = 25'(n * 128);
      dv1 = 1'b1;
      q1.push_back(16'(n));
      step();
    end
    dv1 = 1'b0;
    step();
    step();
    chk("t6 count 3", 32'(cnt1), 3);
    for (int i = 0; i < 8; i++) begin
      m_ready = (i % 2 == 0);
      d_in = 25'((110 + i) * 128);
      dv1 = 1'b1;
      q1.push_back(16'(110 + i));
      step();
    end
    chk("t6 overflow", 32'(ov1), 0);
    chk("t6 dut4 drained", 32'(q4.size()), 0);
    rst = 1'b1;
    dv1 = 1'b0;
    q1.delete();
    #1;
    chk("t6 reset valid", 32'(v1), 0);
    chk("t6 reset data", 32'(d1), 0);
    chk("t6 reset count", 32'(cnt1), 0);
    chk("t6 reset sat", 32'(s1), 0);
    chk("t6 reset dut4 count", 32'(cnt4), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    m_ready = 1'b0;
    d_in = 25'(30 * 128);
    dv1 = 1'b1;
    dv4 = 1'b1;
    q1.push_back(16'd30);
    q4.push_back(16'd30);
    step();
    dv1 = 1'b0;
    dv4 = 1'b0;
    step();
    step();
    chk("t6 head after reset", 32'(d1), 30);
    chk("t6 dut4 kept after reset", 32'(v4), 1);
    m_ready = 1'b1;

    guard = 0;
    while ((q1.size() != 0 || q4.size() != 0) && guard < 100) begin
      step();
      guard++;
    end
    chk("final queues empty", 32'(q1.size() + q4.size()), 0);
    step();
    chk("final dut1 empty", 32'(v1), 0);
    chk("final dut4 empty", 32'(v4), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
